key_debounce: RTL and testbench

//  Conditions a raw, bouncing push-button into clean registered events for downstream counters and LED logic.

---
 rtl/key_debounce_pkg.sv | 15 +
 rtl/key_debounce_sync_2ff.sv | 25 ++
 rtl/key_debounce.sv | 154 +++++++++++++++
 tb/tb_key_debounce.sv | 119 +++++++++++
 4 files changed

// File: rtl/key_debounce_pkg.sv
// Shared definitions for key conditioning logic: FSM state encodings and sizing helpers.
package key_debounce_pkg;

  typedef enum logic [1:0] {
    StIdle       = 2'd0,
    StPressChk   = 2'd1,
    StHeld       = 2'd2,
    StReleaseChk = 2'd3
  } key_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_debounce_sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input, with a selectable reset level.
module key_debounce_sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic s1_q, s2_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_q <= RESET_VAL;
      s2_q <= RESET_VAL;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/key_debounce.sv
// Push-button conditioner: synchronise, debounce, and emit press/release/auto-repeat pulses.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000,
  parameter bit          REPEAT_EN       = 1'b1,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rstn,
  input  logic key_raw,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_repeat,
  output logic key_event
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int unsigned RepW = $clog2(max_u(REPEAT_DELAY, REPEAT_PERIOD)) + 1;
  localparam logic [CntW-1:0] DebMax      = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RepW-1:0] RepDelayMax = RepW'(REPEAT_DELAY - 1);
  localparam logic [RepW-1:0] RepPerMax   = RepW'(REPEAT_PERIOD - 1);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("key_debounce: DEBOUNCE_CYCLES must be >= 2");
  end
  if (REPEAT_DELAY == 0 || REPEAT_PERIOD == 0) begin : g_bad_repeat
    $error("key_debounce: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  logic sync_q;
  logic k;

  key_debounce_sync_2ff #(
    .RESET_VAL(ACTIVE_LOW)
  ) u_sync (
    .clk (clk),
    .rstn(rstn),
    .d   (key_raw),
    .q   (sync_q)
  );

  assign k = sync_q ^ ACTIVE_LOW;

  key_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [RepW-1:0] rep_cnt_q, rep_cnt_d;
  logic            rep_first_q, rep_first_d;
  logic            level_q, level_d;
  logic            press_q, press_d;
  logic            release_q, release_d;
  logic            repeat_q, repeat_d;
  logic            event_q;
  logic            rep_hit;

  // First repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD; counter restarts at each pulse.
  assign rep_hit = (rep_cnt_q == (rep_first_q ? RepDelayMax : RepPerMax));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rep_cnt_d   = rep_cnt_q;
    rep_first_d = rep_first_q;
    level_d     = level_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    repeat_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (k) begin
          state_d = StPressChk;
          cnt_d   = CntW'(1);
        end
      end
      StPressChk: begin
        if (!k) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == DebMax) begin
          state_d     = StHeld;
          cnt_d       = '0;
          press_d     = 1'b1;
          level_d     = 1'b1;
          rep_cnt_d   = '0;
          rep_first_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHeld: begin
        if (!k) begin
          state_d = StReleaseChk;
          cnt_d   = CntW'(1);
        end else if (rep_hit) begin
          repeat_d    = REPEAT_EN;
          rep_cnt_d   = '0;
          rep_first_d = 1'b0;
        end else begin
          rep_cnt_d = rep_cnt_q + 1'b1;
        end
      end
      StReleaseChk: begin
        if (k) begin
          // Bounce rejected: resume the repeat count where it was frozen.
          state_d = StHeld;
          cnt_d   = '0;
          if (!rep_hit) rep_cnt_d = rep_cnt_q + 1'b1;
        end else if (cnt_q == DebMax) begin
          state_d   = StIdle;
          cnt_d     = '0;
          release_d = 1'b1;
          level_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b1;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      repeat_q    <= 1'b0;
      event_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rep_cnt_q   <= rep_cnt_d;
      rep_first_q <= rep_first_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      repeat_q    <= repeat_d;
      event_q     <= press_d | repeat_d;
    end
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_repeat  = repeat_q;
  assign key_event   = event_q;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce: two instances (auto-repeat on/off) share one key input.
module tb_key_debounce;

  logic clk = 1'b0;
  logic rstn;
  logic key_raw;

  logic lvl1, prs1, rel1, rep1, evt1;
  logic lvl2, prs2, rel2, rep2, evt2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  key_debounce #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (8),
    .REPEAT_EN      (1'b1),
    .ACTIVE_LOW     (1'b1)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .key_raw    (key_raw),
    .key_level  (lvl1),
    .key_press  (prs1),
    .key_release(rel1),
    .key_repeat (rep1),
    .key_event  (evt1)
  );

  key_debounce #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (8),
    .REPEAT_EN      (1'b0),
    .ACTIVE_LOW     (1'b1)
  ) dut_norep (
    .clk        (clk),
    .rstn       (rstn),
    .key_raw    (key_raw),
    .key_level  (lvl2),
    .key_press  (prs2),
    .key_release(rel2),
    .key_repeat (rep2),
    .key_event  (evt2)
  );

  task automatic chk(input string tag, input int idx, input logic obs, input logic exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s[%0d] observed=%b expected=%b", tag, idx, obs, exp);
    end
  endtask

  // One clock, then compare every output of both instances against the expected pulses.
  task automatic step(input string tag, input int idx, input logic ep, input logic er,
                      input logic erp, input logic el);
    @(posedge clk);
    #1;
    chk({tag, ".press"},   idx, prs1, ep);
    chk({tag, ".release"}, idx, rel1, er);
    chk({tag, ".repeat"},  idx, rep1, erp);
    chk({tag, ".level"},   idx, lvl1, el);
    chk({tag, ".event"},   idx, evt1, ep | erp);
    chk({tag, ".nr_press"},  idx, prs2, ep);
    chk({tag, ".nr_release"}, idx, rel2, er);
    chk({tag, ".nr_repeat"}, idx, rep2, 1'b0);
    chk({tag, ".nr_level"},  idx, lvl2, el);
    chk({tag, ".nr_event"},  idx, evt2, ep);
  endtask

  initial begin
    // 1: reset with key held, press appears at the 6th edge after rstn rises
    rstn    = 1'b0;
    key_raw = 1'b0;
    for (int i = 1; i <= 3; i++) step("rst", i, 1'b0, 1'b0, 1'b0, 1'b0);
    rstn = 1'b1;
    for (int i = 1; i <= 9; i++) step("t1", i, i == 6, 1'b0, 1'b0, i >= 6);
    key_raw = 1'b1;
    for (int i = 1; i <= 8; i++) step("t1rel", i, 1'b0, i == 6, 1'b0, i < 6);

    // 2: three-cycle glitch is rejected
    key_raw = 1'b0;
    for (int i = 1; i <= 3; i++) step("t2", i, 1'b0, 1'b0, 1'b0, 1'b0);
    key_raw = 1'b1;
    for (int i = 4; i <= 12; i++) step("t2", i, 1'b0, 1'b0, 1'b0, 1'b0);

    // 3: clean press and hold; repeats 20, 28, 36 cycles after the press cycle
    key_raw = 1'b0;
    for (int i = 1; i <= 44; i++)
      step("t3", i, i == 6, 1'b0, (i == 26) || (i == 34) || (i == 42), i >= 6);

    // 4: 2-cycle release bounce; next repeat moves from step 6 to step 8
    key_raw = 1'b1;
    for (int i = 1; i <= 2; i++) step("t4", i, 1'b0, 1'b0, 1'b0, 1'b1);
    key_raw = 1'b0;
    for (int i = 3; i <= 56; i++) step("t4", i, 1'b0, 1'b0, (i % 8) == 0, 1'b1);

    // 5: final release, no repeat while release is being checked
    key_raw = 1'b1;
    for (int i = 1; i <= 10; i++) step("t5", i, 1'b0, i == 6, 1'b0, i < 6);

    // 6: reset while held aborts silently, then a fresh press
    key_raw = 1'b0;
    for (int i = 1; i <= 10; i++) step("t6", i, i == 6, 1'b0, 1'b0, i >= 6);
    rstn = 1'b0;
    for (int i = 1; i <= 2; i++) step("t6rst", i, 1'b0, 1'b0, 1'b0, 1'b0);
    rstn = 1'b1;
    for (int i = 1; i <= 8; i++) step("t6re", i, i == 6, 1'b0, 1'b0, i >= 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
